inlier_tally: RTL

Consumes the per-point `inlier` result stream of `check_inlier`, counts the inliers over a full point cloud for one candidate plane, and retains the best plane seen so far. It sits directly downstream of `check_inlier` in the RANSAC loop. It reports each candidate's inlier count to the iteration controller over a valid/acknowledge handshake.

---
 rtl/inlier_tally_pkg.sv | 37 +++
 rtl/best_plane_register.sv | 70 +++++++
 rtl/inlier_tally.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/inlier_tally_pkg.sv
// ---------------------------------------------------------------------------
// inlier_tally_pkg
//
// Shared vector types for the RANSAC plane-fit pipeline.
//   single_t    : IEEE-754 single-precision value carried as raw bits
//   vector3s_s  : three single_t components {x, y, z}
//   plane_s     : candidate plane {normal n, offset d}
//
// The tally stage never does arithmetic on these values; it only latches,
// stores and forwards them, so they are kept as plain bit containers.
// ---------------------------------------------------------------------------
package inlier_tally_pkg;

    typedef logic [31:0] single_t;

    typedef struct packed {
        single_t x;
        single_t y;
        single_t z;
    } vector3s_s;

    typedef struct packed {
        vector3s_s n;
        single_t   d;
    } plane_s;

    localparam int PLANE_BITS = $bits(plane_s);

    // Bundle a normal and offset into one plane record.
    function automatic plane_s make_plane(input vector3s_s n_in, input single_t d_in);
        plane_s p;
        p.n = n_in;
        p.d = d_in;
        return p;
    endfunction

endpackage : inlier_tally_pkg

// File: rtl/best_plane_register.sv
// ---------------------------------------------------------------------------
// best_plane_register
//
// Holds the best plane found so far together with its inlier count.
//
// Ports
//   clock         : rising-edge clock
//   reset         : asynchronous, active-low
//   i_compare     : one-cycle strobe, candidate is ready to be compared
//   i_clear       : invalidate the stored best (clears valid and count)
//   i_cand        : candidate plane
//   i_cand_count  : candidate inlier count
//   o_best_valid  : a best plane is stored
//   o_best        : stored best plane
//   o_best_count  : inlier count of the stored best plane
//
// A candidate replaces the stored plane only when it is strictly better, so
// ties keep the earlier plane. A clear arriving together with a compare
// makes the compare treat the store as empty: the candidate wins.
// ---------------------------------------------------------------------------
module best_plane_register
    import inlier_tally_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_compare,
    input  logic                   i_clear,
    input  plane_s                 i_cand,
    input  logic [COUNT_WIDTH-1:0] i_cand_count,
    output logic                   o_best_valid,
    output plane_s                 o_best,
    output logic [COUNT_WIDTH-1:0] o_best_count
);

    logic                   r_best_valid;
    plane_s                 r_best;
    logic [COUNT_WIDTH-1:0] r_best_count;

    logic w_store_empty;
    logic w_cand_better;
    logic w_take;

    // Clear has priority over the stored contents as seen by the compare.
    assign w_store_empty = i_clear || !r_best_valid;
    assign w_cand_better = (i_cand_count > r_best_count);
    assign w_take        = i_compare && (w_store_empty || w_cand_better);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_best_valid <= 1'b0;
            r_best       <= '0;
            r_best_count <= '0;
        end else if (w_take) begin
            r_best_valid <= 1'b1;
            r_best       <= i_cand;
            r_best_count <= i_cand_count;
        end else if (i_clear) begin
            // The plane itself is left in place; only validity and count drop.
            r_best_valid <= 1'b0;
            r_best_count <= '0;
        end
    end

    assign o_best_valid = r_best_valid;
    assign o_best       = r_best;
    assign o_best_count = r_best_count;

endmodule : best_plane_register

// File: rtl/inlier_tally.sv
// ---------------------------------------------------------------------------
// inlier_tally
//
// Counts inliers reported by check_inlier over one point cloud for one
// candidate plane, reports the count to the iteration controller and keeps
// the best plane seen so far.
//
// Ports
//   clock, reset   : rising-edge clock, asynchronous active-low reset
//   start          : begin a tally (only honoured in IDLE)
//   n, d           : candidate plane, latched on accepted start
//   point_count    : number of samples to consume, latched on accepted start
//   busy           : high in every state except IDLE
//   ivalid, inlier : sample stream from check_inlier
//   oacknowledge   : sample accept, high exactly while counting
//   rvalid         : result for the current candidate is available
//   racknowledge   : controller consumes the result
//   count          : inlier count of the last finished candidate
//   best_valid, best_n, best_d, best_count : stored best plane
//   clear_best     : invalidate the stored best plane
//
// Flow: IDLE -> COUNT (skipped when point_count is 0) -> COMPARE (one cycle)
//       -> REPORT (until racknowledge) -> IDLE.
// ---------------------------------------------------------------------------
module inlier_tally
    import inlier_tally_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  vector3s_s              n,
    input  single_t                d,
    input  logic [COUNT_WIDTH-1:0] point_count,
    output logic                   busy,
    input  logic                   ivalid,
    input  logic                   inlier,
    output logic                   oacknowledge,
    output logic                   rvalid,
    input  logic                   racknowledge,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   best_valid,
    output vector3s_s              best_n,
    output single_t                best_d,
    output logic [COUNT_WIDTH-1:0] best_count,
    input  logic                   clear_best
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_COMPARE,
        ST_REPORT
    } state_e;

    state_e                 r_state;
    plane_s                 r_cand;
    logic [COUNT_WIDTH-1:0] r_point_count;
    logic [COUNT_WIDTH-1:0] r_seen;
    logic [COUNT_WIDTH-1:0] r_inliers;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_busy;
    logic                   r_rvalid;

    logic [COUNT_WIDTH-1:0] w_seen_next;
    logic                   w_accept;
    logic                   w_last_sample;
    logic                   w_compare;
    plane_s                 w_best;

    assign w_seen_next   = r_seen + COUNT_WIDTH'(1);
    assign w_accept      = (r_state == ST_COUNT) && ivalid;
    // The inlier counter can never exceed seen, which can never exceed
    // point_count, so neither counter can wrap.
    assign w_last_sample = w_accept && (w_seen_next == r_point_count);
    assign w_compare     = (r_state == ST_COMPARE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cand        <= '0;
            r_point_count <= '0;
            r_seen        <= '0;
            r_inliers     <= '0;
            r_count       <= '0;
            r_busy        <= 1'b0;
            r_rvalid      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cand        <= make_plane(n, d);
                        r_point_count <= point_count;
                        r_seen        <= '0;
                        r_inliers     <= '0;
                        r_busy        <= 1'b1;
                        // An empty cloud goes straight to the compare with 0.
                        r_state       <= (point_count != '0) ? ST_COUNT : ST_COMPARE;
                    end
                end

                ST_COUNT: begin
                    if (w_accept) begin
                        r_seen <= w_seen_next;
                        if (inlier) begin
                            r_inliers <= r_inliers + COUNT_WIDTH'(1);
                        end
                    end
                    if (w_last_sample) begin
                        r_state <= ST_COMPARE;
                    end
                end

                ST_COMPARE: begin
                    // Best-plane update happens in the sub-module on this cycle.
                    r_count  <= r_inliers;
                    r_rvalid <= 1'b1;
                    r_state  <= ST_REPORT;
                end

                ST_REPORT: begin
                    // start is deliberately not looked at here, even on the
                    // acknowledge cycle.
                    if (racknowledge) begin
                        r_rvalid <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end

                default: begin
                    r_rvalid <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    best_plane_register #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_best (
        .clock        (clock),
        .reset        (reset),
        .i_compare    (w_compare),
        .i_clear      (clear_best),
        .i_cand       (r_cand),
        .i_cand_count (r_inliers),
        .o_best_valid (best_valid),
        .o_best       (w_best),
        .o_best_count (best_count)
    );

    // Upstream handshake follows the state directly so it drops the cycle
    // after the last sample is taken.
    assign oacknowledge = (r_state == ST_COUNT);
    assign busy         = r_busy;
    assign rvalid       = r_rvalid;
    assign count        = r_count;
    assign best_n       = w_best.n;
    assign best_d       = w_best.d;

endmodule : inlier_tally
